// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, baud helper and ASCII constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} uart_state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  localparam logic [7:0] ASCII_E = 8'h65;
  localparam logic [7:0] ASCII_I = 8'h49;
  localparam logic [7:0] ASCII_LI = 8'h69;
  localparam logic [7:0] ASCII_L = 8'h6C;
  localparam logic [7:0] ASCII_O = 8'h6F;
  localparam logic [7:0] ASCII_U = 8'h75;
  localparam logic [7:0] ASCII_V = 8'h76;
  localparam logic [7:0] ASCII_Y = 8'h79;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage single-bit synchronizer with configurable reset value.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr_q, sr_d;
  always_comb sr_d = {sr_q[STAGES-2:0], d};
  always_ff @(posedge clk) sr_q <= rst ? {STAGES{RST_VAL}} : sr_d;
  assign q = sr_q[STAGES-1];
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver producing one byte per frame with valid/framing-error strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CPB_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d, data_q, data_d;
  logic dv_q, dv_d, fe_q, fe_d, rx_s;
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst(rst), .d(rx_in), .q(rx_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    shreg_d = shreg_q;
    data_d = data_q;
    dv_d = 1'b0;
    fe_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF_M1) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == CPB_M1) begin
        cnt_d = '0;
        shreg_d = {rx_s, shreg_q[7:1]};
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      // Returning to IDLE at the stop midpoint leaves half a bit to catch a back-to-back start edge
      STOP: if (cnt_q == CPB_M1) begin
        cnt_d = '0;
        dv_d = rx_s;
        fe_d = !rx_s;
        data_d = rx_s ? shreg_q : data_q;
        state_d = rx_s ? IDLE : RECOVER;
      end
      RECOVER: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : RECOVER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shreg_q <= '0;
      data_q <= '0;
      dv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shreg_q <= shreg_d;
      data_q <= data_d;
      dv_q <= dv_d;
      fe_q <= fe_d;
    end
  end
  assign data_out = data_q;
  assign data_valid = dv_q;
  assign frame_err = fe_q;
  assign busy = state_q != IDLE;
endmodule
